// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-enabled data memory.
// - SIZE_* : request size encodings (2'b11 behaves as a word access)
// - state_t: request/response FSM states
// - misaligned(): alignment check from access size and byte lane
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Halfwords need an even lane; words (and the 2'b11 alias) need lane 0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lane[0];
      default:   misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response bus of the data memory.
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1; all req_* fields, address and write_data are sampled
// only on that edge. resp_valid is a one-cycle strobe with no backpressure:
// read_data/err_* are meaningful only while it is high (read_data is 0 otherwise).
// - master: issues requests (load/store unit or testbench)
// - slave : the memory
interface data_memory_be_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic                  resp_valid;
  logic [31:0]           read_data;
  logic                  err_misalign;
  logic                  err_range;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, write_data,
    input  req_ready, resp_valid, read_data, err_misalign, err_range
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, write_data,
    output req_ready, resp_valid, read_data, err_misalign, err_range
  );
endinterface

// File: rtl/data_memory_be_load_store_align.sv
// Combinational lane steering for MIPS byte/halfword/word accesses.
// Inputs : size, lane (address[1:0]), zero_ext, write_data (right-aligned), raw_word
// Outputs: byte_en (per-byte write enables), store_word (data replicated
//          onto every lane), load_value (selected lane shifted to bit 0, extended)
module load_store_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  input  logic [31:0] write_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = raw_word[{lane, 3'b000} +: 8];
    sel_half   = lane[1] ? raw_word[31:16] : raw_word[15:0];
    byte_en    = 4'b1111;
    store_word = write_data;
    load_value = raw_word;
    case (size)
      SIZE_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{write_data[7:0]}};
        load_value = zero_ext ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SIZE_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
        load_value = zero_ext ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: begin
        byte_en    = 4'b1111;
        store_word = write_data;
        load_value = raw_word;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-enabled data memory with a valid/ready request port.
// Ports:
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : data_memory_be_if slave (requests in, one-cycle response strobe out)
// - state      : current FSM state, for observation
// Stores write the array at the accepting edge and respond one cycle later;
// loads respond READ_LATENCY cycles after acceptance. Misaligned or
// out-of-range accesses write nothing and return 0 with the error flags set.
module data_memory_be
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_be_if.slave  bus,
  output state_t           state
);

  localparam int INDEX_BITS = $clog2(DEPTH_WORDS);
  localparam int WORD_BITS  = ADDR_WIDTH - 2;
  // Wait-cycle count loaded on entry to WAIT; only used when READ_LATENCY > 1.
  localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  logic [31:0] mem [DEPTH_WORDS];

  logic [WORD_BITS-1:0]  word_idx;
  logic [INDEX_BITS-1:0] mem_idx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  err_mis;
  logic                  err_rng;
  logic                  do_store;
  logic [3:0]            byte_en;
  logic [31:0]           store_word;
  logic [31:0]           load_value;
  logic [31:0]           raw_word;
  state_t                state_next;
  logic [1:0]            cnt;
  logic [1:0]            cnt_next;
  logic [31:0]           data_q;
  logic                  mis_q;
  logic                  rng_q;

  assign lane     = bus.address[1:0];
  assign word_idx = bus.address[ADDR_WIDTH-1:2];
  assign mem_idx  = word_idx[INDEX_BITS-1:0];
  // Compare the full word index so high address bits never alias into the array.
  assign err_rng  = (word_idx >= WORD_BITS'(DEPTH_WORDS));
  assign err_mis  = misaligned(bus.req_size, lane);

  assign bus.req_ready = (state != WAIT);
  assign accept        = bus.req_valid && bus.req_ready;
  assign do_store      = accept && bus.req_write && !err_mis && !err_rng;
  assign raw_word      = mem[mem_idx];

  load_store_align u_align (
    .size       (bus.req_size),
    .lane       (lane),
    .zero_ext   (bus.req_unsigned),
    .write_data (bus.write_data),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_value (load_value)
  );

  // Array is deliberately not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (do_store && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[mem_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, RESP: begin
        state_next = IDLE;
        if (accept) begin
          if (!bus.req_write && (READ_LATENCY > 1)) begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 2'd0) state_next = RESP;
        else             cnt_next   = cnt - 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The load result is read at acceptance: no store can be accepted while a
  // load waits, so the word cannot change before the response goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      data_q <= 32'd0;
      mis_q  <= 1'b0;
      rng_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        data_q <= (bus.req_write || err_mis || err_rng) ? 32'd0 : load_value;
        mis_q  <= err_mis;
        rng_q  <= err_rng;
      end
    end
  end

  assign bus.resp_valid   = (state == RESP);
  assign bus.read_data    = bus.resp_valid ? data_q : 32'd0;
  assign bus.err_misalign = bus.resp_valid && mis_q;
  assign bus.err_range    = bus.resp_valid && rng_q;

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
Parametrised successor to the mono-cycle data memory, used as the load/store unit backing store.
- Adds MIPS byte/halfword/word access (lb/lbu/lh/lhu/lw/sb/sh/sw) with per-byte write enables and sign/zero extension.
- Adds configurable depth and a read latency of 1..3 cycles behind a valid/ready request port.
- Reports misaligned and out-of-range accesses instead of silently aliasing.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- ADDR_WIDTH, 32: byte-address width.
- READ_LATENCY, 1: cycles from read acceptance to response; legal values 1, 2, 3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored on stores.
- address  in  ADDR_WIDTH  byte address.
- write_data  in  32  store data, right-aligned: the byte is in [7:0], the halfword in [15:0].
- resp_valid  out  1  one-cycle response strobe, for both loads and stores.
- read_data  out  32  extended load result; 0 whenever resp_valid=0, for stores, and for errored loads.
- err_misalign  out  1  valid with resp_valid.
- err_range  out  1  valid with resp_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, resp_valid=0, read_data=0, err_*=0, req_ready=1.
  - Memory array is not reset; simulation initialises it to 0.
  - Reset mid-read drops the pending response; memory is unchanged.
- Request acceptance: accept = req_valid && req_ready at a rising edge. Request fields are sampled only at acceptance.
- Addressing:
  - Little-endian: byte lane = address[1:0].
  - Word index = address[ADDR_WIDTH-1:2].
- Misalignment check:
  - Halfword with address[0]=1 is misaligned.
  - Word with address[1:0]!=0 is misaligned.
- Range check: word index >= DEPTH_WORDS sets err_range. Index bits above log2(DEPTH_WORDS) are checked, never truncated.
- Errors:
  - Any error suppresses the store (no byte written) and forces read_data=0.
  - Both flags may assert together.
- Stores:
  - Memory is updated at the acceptance edge N, using byte enables derived from size and lane.
  - The sb byte is replicated to its lane; the sh halfword goes to lane 0 or 2.
  - resp_valid=1 during cycle N..N+1, regardless of READ_LATENCY.
- Loads:
  - Accepted at edge N, resp_valid=1 during the cycle following edge N+READ_LATENCY-1.
  - Result: the selected byte or halfword is shifted to bit 0, then sign- or zero-extended.
- FSM:
  - IDLE: on a load with READ_LATENCY>1 -> WAIT with cnt=READ_LATENCY-2. On a store, or a load with READ_LATENCY=1 -> RESP. No accept -> stay in IDLE.
  - WAIT: req_ready=0. cnt>0 -> decrement cnt. cnt=0 -> RESP.
  - RESP: resp_valid=1, req_ready=1. A new accept follows the same rules as in IDLE; no accept -> IDLE.
- Throughput: back-to-back requests (one per cycle) are sustained for stores and for READ_LATENCY=1 loads.
- Read-after-write: a store at edge N followed by a load accepted at edge N+1 to the same word returns the new data.
- No response backpressure: the consumer must take resp_valid when it is asserted.

Decomposition:
- Package data_memory_pkg:
  - Size encoding constants SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - State enum IDLE/WAIT/RESP.
  - Function computing the misalign flag from size and address[1:0].
- Sub-module load_store_align (combinational):
  - Inputs: size, lane, unsigned, write_data, raw word.
  - Outputs: 4-bit byte enable, lane-replicated store word, extended load value.
- Top holds the array, the latency pipeline/counter, the FSM, and the range check.

Test Plan:
1. READ_LATENCY=1: sw 0x11223344 @0x8; lw @0x8 accepted the next cycle -> resp_valid one cycle later, read_data=0x11223344, err_*=0.
2. sb 0xAB @0x9, then lb @0x9 -> 0xFFFFFFAB; lbu @0x9 -> 0x000000AB; lw @0x8 -> 0x1122AB44.
3. sh 0x8001 @0xE; lh @0xE -> 0xFFFF8001; lhu -> 0x00008001. lh @0xF -> err_misalign=1, read_data=0, memory unchanged.
4. DEPTH_WORDS=1024: sw 0xFFFFFFFF @0xFFC (index 1023) -> stored and reads back. sw @0x1000 -> err_range=1, and word 0 still reads as its old value (no aliasing).
5. READ_LATENCY=3: lw accepted at edge N -> req_ready=0 for 2 cycles, resp_valid in the cycle after edge N+2. A req_valid held during WAIT is accepted only in RESP.
6. Reset asserted during WAIT -> resp_valid stays 0, req_ready=1 immediately, previously stored data intact after rst_n deasserts.
